dff_share_arbiter: RTL

- Round-robin write arbiter for a shared WIDTH-bit D-flip-flop storage register.
- Up to N_REQ requesters compete to load the register. The block grants one requester at a time, commits its data into the register and acknowledges each committed write.
- A granted requester may lock the register for a bounded burst of back-to-back writes.
- The block sits between requester logic and the shared flip-flop bank; it owns the register and presents its value as `q`.

---
 rtl/dff_share_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter: round-robin write arbiter that owns a shared WIDTH-bit
// register. One requester is granted at a time; a granted requester may lock
// the register for a bounded burst of back-to-back writes.
module dff_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           ack,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Round-robin successor: wraps from the last requester back to 0.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (idx == LAST_IDX) begin
      return {IW{1'b0}};
    end else begin
      return idx + IW'(1);
    end
  endfunction

  // Returns {found, index} of the first active request at or after ptr.
  function automatic logic [IW:0] pick_winner(input logic [N_REQ-1:0] r,
                                              input logic [IW-1:0]    p);
    logic          found;
    logic [IW-1:0] idx;
    int            c;
    found = 1'b0;
    idx   = {IW{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      c = int'(p) + k;
      if (c >= N_REQ) begin
        c = c - N_REQ;
      end else begin
        c = c;
      end
      if (!found && r[c]) begin
        found = 1'b1;
        idx   = IW'(c);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  state_t            state_r, state_s;
  logic [N_REQ-1:0]  grant_r, grant_s;
  logic [N_REQ-1:0]  ack_r,   ack_s;
  logic [WIDTH-1:0]  q_r,     q_s;
  logic [IW-1:0]     owner_r, owner_s;
  logic [IW-1:0]     ptr_r,   ptr_s;
  logic [IW-1:0]     gidx_r,  gidx_s;
  logic [HW-1:0]     hold_r,  hold_s;
  logic              busy_r,  busy_s;

  logic [IW:0]       win_s;
  logic              wr_s;
  logic              lk_s;
  logic [WIDTH-1:0]  wslice_s;

  assign grant = grant_r;
  assign ack   = ack_r;
  assign q     = q_r;
  assign owner = owner_r;
  assign busy  = busy_r;

  // Next-state, grant, write-commit and pointer logic.
  always_comb begin
    state_s  = state_r;
    grant_s  = grant_r;
    ack_s    = {N_REQ{1'b0}};
    q_s      = q_r;
    owner_s  = owner_r;
    ptr_s    = ptr_r;
    gidx_s   = gidx_r;
    hold_s   = hold_r;
    win_s    = pick_winner(req, ptr_r);
    wr_s     = req[gidx_r];
    lk_s     = lock[gidx_r];
    wslice_s = wdata[int'(gidx_r)*WIDTH +: WIDTH];

    case (state_r)
      ST_IDLE: begin
        if (win_s[IW]) begin
          grant_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_s[IW-1:0];
          gidx_s  = win_s[IW-1:0];
          state_s = ST_GRANT;
        end else begin
          grant_s = {N_REQ{1'b0}};
        end
      end
      ST_GRANT: begin
        if (wr_s) begin
          q_s            = wslice_s;
          owner_s        = gidx_r;
          ack_s[gidx_r]  = 1'b1;
        end else begin
          q_s = q_r;
        end
        // A lock only counts alongside a committed write; a withdrawn
        // request always releases the register.
        if (wr_s && lk_s) begin
          state_s = ST_HOLD;
          hold_s  = {HW{1'b0}};
        end else begin
          state_s = ST_IDLE;
          grant_s = {N_REQ{1'b0}};
          ptr_s   = next_idx(gidx_r);
        end
      end
      ST_HOLD: begin
        if (wr_s) begin
          q_s            = wslice_s;
          owner_s        = gidx_r;
          ack_s[gidx_r]  = 1'b1;
        end else begin
          q_s = q_r;
        end
        if (!lk_s || (hold_r == HOLD_LAST)) begin
          state_s = ST_IDLE;
          grant_s = {N_REQ{1'b0}};
          ptr_s   = next_idx(gidx_r);
          hold_s  = {HW{1'b0}};
        end else begin
          hold_s  = hold_r + HW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = {N_REQ{1'b0}};
        hold_s  = {HW{1'b0}};
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset discards any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      grant_r <= {N_REQ{1'b0}};
      ack_r   <= {N_REQ{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      owner_r <= {IW{1'b0}};
      ptr_r   <= {IW{1'b0}};
      gidx_r  <= {IW{1'b0}};
      hold_r  <= {HW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      ack_r   <= ack_s;
      q_r     <= q_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      gidx_r  <= gidx_s;
      hold_r  <= hold_s;
      busy_r  <= busy_s;
    end
  end

endmodule
